// File: rtl/dso_uart_pkg.sv
// Shared UART definitions for the DSO command link: FSM state encoding,
// frame width and the command/response byte values used by the dispatcher.
package dso_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   localparam int UART_BITS = 8;

   localparam logic [7:0] DUMP_CH    = 8'h01;
   localparam logic [7:0] CFG_TRG    = 8'h02;
   localparam logic [7:0] TRG_POS_WR = 8'h03;
   localparam logic [7:0] TRG_POS_RD = 8'h04;
   localparam logic [7:0] CFG_GAIN   = 8'h05;
   localparam logic [7:0] CFG_OFFSET = 8'h06;
   localparam logic [7:0] SET_DEC    = 8'h07;
   localparam logic [7:0] EEP_WR     = 8'h08;
   localparam logic [7:0] EEP_RD     = 8'h09;

   localparam logic [7:0] ACK = 8'hA5;
   localparam logic [7:0] NAK = 8'hEE;

   function automatic logic [23:0] pack_cmd(input logic [7:0] b0,
                                             input logic [7:0] b1,
                                             input logic [7:0] b2);
      return {b0, b1, b2};
   endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: one start bit, eight data bits LSB first, one stop bit.
// A new frame may be started in the last stop-bit cycle for gapless output.
module uart_tx_core
   import dso_uart_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [UART_BITS-1:0] data,
   input  logic                 start,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(UART_BITS - 1);

   uart_state_t          state_reg, state_next;
   logic [CW-1:0]        baud_reg, baud_next;
   logic [2:0]           bit_reg, bit_next;
   logic [UART_BITS-1:0] shift_reg, shift_next;
   logic                 tx_reg, tx_next;
   logic                 bit_end;

   assign bit_end = (baud_reg == BAUD_LAST);
   assign done    = (state_reg == ST_STOP) && bit_end && !rst;
   assign busy    = (state_reg != ST_IDLE) && !done && !rst;
   // Line forced idle during reset so a truncated frame never lingers.
   assign tx      = tx_reg | rst;

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      unique case (state_reg)
         ST_IDLE: begin
            baud_next = '0;
            if (start) begin
               shift_next = data;
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               baud_next  = '0;
               bit_next   = '0;
               state_next = ST_DATA;
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_next  = '0;
               shift_next = {1'b0, shift_reg[UART_BITS-1:1]};
               if (bit_reg == BIT_LAST) begin
                  state_next = ST_STOP;
               end else begin
                  bit_next = bit_reg + 1'b1;
               end
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               baud_next = '0;
               if (start) begin
                  shift_next = data;
                  state_next = ST_START;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      unique case (state_next)
         ST_START: tx_next = 1'b0;
         ST_DATA:  tx_next = shift_next[0];
         default:  tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         tx_reg    <= tx_next;
      end
   end

endmodule

// File: rtl/uart_comm_slv.sv
// Host-facing UART endpoint: assembles three received bytes into a 24-bit
// command with inter-byte timeout, and transmits single response bytes.
module uart_comm_slv
   import dso_uart_pkg::*;
#(
   parameter int BAUD_DIV  = 2604,
   parameter int GAP_BAUDS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        tx_busy,
   output logic        resp_sent
);

   localparam int CW         = $clog2(BAUD_DIV);
   localparam int GAP_CYCLES = GAP_BAUDS * BAUD_DIV;
   localparam int GW         = $clog2(GAP_CYCLES);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(UART_BITS - 1);

   logic                 rx_meta_reg, rx_sync_reg;
   uart_state_t          rx_state_reg, rx_state_next;
   logic [CW-1:0]        rx_cnt_reg, rx_cnt_next;
   logic [2:0]           rx_bit_reg, rx_bit_next;
   logic [UART_BITS-1:0] rx_shift_reg, rx_shift_next;
   logic                 rx_armed_reg, rx_armed_next;
   logic                 byte_ok, frame_err;

   logic [1:0]           byte_cnt_reg, byte_cnt_next;
   logic [7:0]           shadow0_reg, shadow0_next;
   logic [7:0]           shadow1_reg, shadow1_next;
   logic [GW-1:0]        gap_reg, gap_next;
   logic [23:0]          cmd_reg, cmd_next;
   logic                 cmd_rdy_reg, cmd_rdy_next;

   assign cmd     = cmd_reg;
   assign cmd_rdy = cmd_rdy_reg;

   // RX bit-level FSM; rx_armed blocks a held-low line from re-triggering.
   always_comb begin
      rx_state_next = rx_state_reg;
      rx_cnt_next   = rx_cnt_reg;
      rx_bit_next   = rx_bit_reg;
      rx_shift_next = rx_shift_reg;
      rx_armed_next = rx_armed_reg | rx_sync_reg;
      byte_ok       = 1'b0;
      frame_err     = 1'b0;
      unique case (rx_state_reg)
         ST_IDLE: begin
            rx_cnt_next = '0;
            if (!rx_sync_reg && rx_armed_reg) begin
               rx_state_next = ST_START;
            end
         end
         ST_START: begin
            if (rx_cnt_reg == HALF_LAST) begin
               rx_cnt_next = '0;
               rx_bit_next = '0;
               rx_state_next = rx_sync_reg ? ST_IDLE : ST_DATA;
            end else begin
               rx_cnt_next = rx_cnt_reg + 1'b1;
            end
         end
         ST_DATA: begin
            if (rx_cnt_reg == BAUD_LAST) begin
               rx_cnt_next   = '0;
               rx_shift_next = {rx_sync_reg, rx_shift_reg[UART_BITS-1:1]};
               if (rx_bit_reg == BIT_LAST) begin
                  rx_state_next = ST_STOP;
               end else begin
                  rx_bit_next = rx_bit_reg + 1'b1;
               end
            end else begin
               rx_cnt_next = rx_cnt_reg + 1'b1;
            end
         end
         ST_STOP: begin
            if (rx_cnt_reg == BAUD_LAST) begin
               rx_cnt_next   = '0;
               rx_state_next = ST_IDLE;
               if (rx_sync_reg) begin
                  byte_ok = 1'b1;
               end else begin
                  frame_err     = 1'b1;
                  rx_armed_next = 1'b0;
               end
            end else begin
               rx_cnt_next = rx_cnt_reg + 1'b1;
            end
         end
         default: rx_state_next = ST_IDLE;
      endcase
   end

   // Command assembly, inter-byte timeout and the cmd_rdy handshake.
   always_comb begin
      byte_cnt_next = byte_cnt_reg;
      shadow0_next  = shadow0_reg;
      shadow1_next  = shadow1_reg;
      gap_next      = '0;
      cmd_next      = cmd_reg;
      cmd_rdy_next  = cmd_rdy_reg;
      if (clr_cmd_rdy) begin
         cmd_rdy_next = 1'b0;
      end
      if (frame_err) begin
         byte_cnt_next = '0;
      end else if (byte_ok) begin
         unique case (byte_cnt_reg)
            2'd0: begin
               shadow0_next  = rx_shift_reg;
               byte_cnt_next = 2'd1;
            end
            2'd1: begin
               shadow1_next  = rx_shift_reg;
               byte_cnt_next = 2'd2;
            end
            default: begin
               cmd_next      = pack_cmd(shadow0_reg, shadow1_reg, rx_shift_reg);
               cmd_rdy_next  = 1'b1;
               byte_cnt_next = 2'd0;
            end
         endcase
      end else if (rx_state_reg == ST_IDLE && byte_cnt_reg != 2'd0) begin
         if (gap_reg == GAP_LAST) begin
            byte_cnt_next = '0;
            shadow0_next  = '0;
            shadow1_next  = '0;
         end else begin
            gap_next = gap_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_reg  <= 1'b1;
         rx_sync_reg  <= 1'b1;
         rx_state_reg <= ST_IDLE;
         rx_cnt_reg   <= '0;
         rx_bit_reg   <= '0;
         rx_shift_reg <= '0;
         rx_armed_reg <= 1'b1;
         byte_cnt_reg <= '0;
         shadow0_reg  <= '0;
         shadow1_reg  <= '0;
         gap_reg      <= '0;
         cmd_reg      <= '0;
         cmd_rdy_reg  <= 1'b0;
      end else begin
         rx_meta_reg  <= RX;
         rx_sync_reg  <= rx_meta_reg;
         rx_state_reg <= rx_state_next;
         rx_cnt_reg   <= rx_cnt_next;
         rx_bit_reg   <= rx_bit_next;
         rx_shift_reg <= rx_shift_next;
         rx_armed_reg <= rx_armed_next;
         byte_cnt_reg <= byte_cnt_next;
         shadow0_reg  <= shadow0_next;
         shadow1_reg  <= shadow1_next;
         gap_reg      <= gap_next;
         cmd_reg      <= cmd_next;
         cmd_rdy_reg  <= cmd_rdy_next;
      end
   end

   uart_tx_core #(
      .BAUD_DIV(BAUD_DIV)
   ) u_tx (
      .clk  (clk),
      .rst  (rst),
      .data (resp),
      .start(send_resp),
      .tx   (TX),
      .busy (tx_busy),
      .done (resp_sent)
   );

endmodule
